// File: rtl/ppg_pkg.sv
// ppg_pkg: shared definitions for the pulse-oximeter sample path.
//   seq_state_t : LED/ADC sequencer states
//   phase_t     : LED phase encoding (PH_RED=0, PH_IR=1)
//   PPG_*       : default timing/width constants, shared with the FIR and top level
package ppg_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_CONVERT = 3'd3,
    S_HOLD    = 3'd4
  } seq_state_t;

  typedef enum logic {
    PH_RED = 1'b0,
    PH_IR  = 1'b1
  } phase_t;

  localparam int PPG_DATA_W         = 8;   // ADC sample width == FIR input width
  localparam int PPG_PHASE_CYCLES   = 50;  // clocks per LED phase, including the dead cycle
  localparam int PPG_SETTLE_CYCLES  = 10;  // LED-on clocks before the conversion request
  localparam int PPG_TIMEOUT_CYCLES = 20;  // clocks after adc_start that adc_done may still arrive

endpackage

// File: rtl/led_phase_timer.sv
// led_phase_timer: counts clocks within one LED phase and tracks which LED owns the phase.
//   CLK_Filter, rst_n : clock, asynchronous active-low reset
//   run               : advance the counter this clock
//   clear             : force cnt=0, phase_sel=PH_RED (dominates run)
//   cnt               : position within the phase, 0..PHASE_CYCLES-1
//   last              : cnt is at PHASE_CYCLES-1 (wraps on the next run clock)
//   phase_sel         : current LED phase, toggles on each wrap
import ppg_pkg::*;

module led_phase_timer #(
  parameter int PHASE_CYCLES = PPG_PHASE_CYCLES,
  parameter int CNT_W        = $clog2(PHASE_CYCLES)
) (
  input  logic             CLK_Filter,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output phase_t           phase_sel
);

  assign last = (cnt == CNT_W'(PHASE_CYCLES - 1));

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order in which always blocks are evaluated.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      phase_sel <= PH_RED;
    end else if (clear) begin
      cnt       <= '0;
      phase_sel <= PH_RED;
    end else if (run) begin
      if (last) begin
        cnt       <= '0;
        phase_sel <= (phase_sel == PH_RED) ? PH_IR : PH_RED;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_adc_sequencer.sv
// led_adc_sequencer: alternates red/IR LEDs, one phase each, and runs one ADC conversion per
// phase after LED settling, steering the result to the matching channel register.
//   CLK_Filter, rst_n        : clock, asynchronous active-low reset
//   enable                   : run the sequencer; low stops it with LEDs off
//   err_clr                  : clears adc_timeout_err (a new timeout in the same clock wins)
//   adc_done, adc_data       : conversion-finished pulse and its result
//   adc_start                : 1-clk conversion request
//   led_red, led_ir          : LED drives, never high together
//   RED_ADC_Value, ir...     : last good sample per channel, held
//   red_valid, ir_valid      : 1-clk strobe when the matching value register updates
//   adc_timeout_err          : sticky flag, conversion not answered in time
import ppg_pkg::*;

module led_adc_sequencer #(
  parameter int DATA_W         = PPG_DATA_W,
  parameter int PHASE_CYCLES   = PPG_PHASE_CYCLES,
  parameter int SETTLE_CYCLES  = PPG_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = PPG_TIMEOUT_CYCLES
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_start,
  output logic              led_red,
  output logic              led_ir,
  output logic [DATA_W-1:0] RED_ADC_Value,
  output logic [DATA_W-1:0] IR_ADC_Value,
  output logic              red_valid,
  output logic              ir_valid,
  output logic              adc_timeout_err
);

  localparam int CNT_W = $clog2(PHASE_CYCLES);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             phase_last;
  phase_t           phase_sel;
  logic             start_next;
  logic             take_sample;
  logic             timeout_hit;
  logic             led_next;

  // Dropping enable clears the timer on the same edge the FSM returns to IDLE,
  // so a re-enable always starts from RED at count 0.
  led_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .CLK_Filter(CLK_Filter),
    .rst_n     (rst_n),
    .run       (state != S_IDLE),
    .clear     (!enable || state == S_IDLE),
    .cnt       (phase_cnt),
    .last      (phase_last),
    .phase_sel (phase_sel)
  );

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Wait counter reads 0 in the adc_start clock; adc_done is still accepted while it
  // reads TIMEOUT_CYCLES, which is also the clock where a missing answer times out.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state != S_CONVERT) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    start_next  = 1'b0;
    take_sample = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE:   if (enable) next_state = S_DEAD;
      S_DEAD:   next_state = S_SETTLE;
      S_SETTLE: begin
        if (phase_cnt == CNT_W'(SETTLE_CYCLES)) begin
          next_state = S_CONVERT;
          start_next = 1'b1;
        end
      end
      S_CONVERT: begin
        if (adc_done) begin
          take_sample = 1'b1;
          next_state  = S_HOLD;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
          next_state  = S_HOLD;
        end
      end
      S_HOLD:   if (phase_last) next_state = S_DEAD;
      default:  next_state = S_IDLE;
    endcase
    // Disable overrides everything: an in-flight conversion is abandoned silently.
    if (!enable) begin
      next_state  = S_IDLE;
      start_next  = 1'b0;
      take_sample = 1'b0;
      timeout_hit = 1'b0;
    end
    led_next = next_state inside {S_SETTLE, S_CONVERT, S_HOLD};
  end

  // Outputs are registered from next-state decode. phase_sel only changes on the
  // edge into DEAD, where led_next is 0, so the two LEDs can never overlap.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      adc_start       <= 1'b0;
      led_red         <= 1'b0;
      led_ir          <= 1'b0;
      red_valid       <= 1'b0;
      ir_valid        <= 1'b0;
      RED_ADC_Value   <= '0;
      IR_ADC_Value    <= '0;
      adc_timeout_err <= 1'b0;
    end else begin
      adc_start <= start_next;
      led_red   <= led_next && (phase_sel == PH_RED);
      led_ir    <= led_next && (phase_sel == PH_IR);
      red_valid <= take_sample && (phase_sel == PH_RED);
      ir_valid  <= take_sample && (phase_sel == PH_IR);
      if (take_sample && phase_sel == PH_RED) RED_ADC_Value <= adc_data;
      if (take_sample && phase_sel == PH_IR)  IR_ADC_Value  <= adc_data;
      if (timeout_hit)  adc_timeout_err <= 1'b1;
      else if (err_clr) adc_timeout_err <= 1'b0;
    end
  end

endmodule
